// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store, with a completion timeout.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT consecutive contended data grants.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT      = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_addrctl,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_addrctl,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);
    localparam int unsigned TCNT_W = 8;
    localparam int unsigned SCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    generate
        if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
            $error("mem_port_arbiter: TIMEOUT must be 2..255");
        end
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve
            $error("mem_port_arbiter: STARVE_LIMIT must be 1..15");
        end
    endgenerate

    state_t             r_state;
    logic [TCNT_W-1:0]  r_tcnt;
    logic               r_if_ack;
    logic [31:0]        r_if_rdata;
    logic               r_d_ack;
    logic [31:0]        r_d_rdata;
    logic               r_err;
    logic               r_mem_en;
    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [2:0]         r_mem_addrctl;

    state_t             w_state_nxt;
    logic [TCNT_W-1:0]  w_tcnt_nxt;
    logic               w_if_ack_nxt;
    logic [31:0]        w_if_rdata_nxt;
    logic               w_d_ack_nxt;
    logic [31:0]        w_d_rdata_nxt;
    logic               w_err_nxt;
    logic               w_mem_en_nxt;
    logic               w_mem_we_nxt;
    logic [31:0]        w_mem_addr_nxt;
    logic [31:0]        w_mem_wdata_nxt;
    logic [2:0]         w_mem_addrctl_nxt;

    logic               w_if_pend;
    logic               w_d_pend;
    logic               w_force_i;
    logic               w_grant_i;
    logic               w_grant_d;
    logic               w_done;
    logic [31:0]        w_rd_data;

    // A port being acknowledged this cycle still shows its old request; ignore it.
    assign w_if_pend = if_req & ~r_if_ack;
    assign w_d_pend  = d_req & ~r_d_ack;

`ifdef ARB_STARVE_GUARD_EN
    logic [SCNT_W-1:0]  r_scnt;
    logic [SCNT_W-1:0]  w_scnt_nxt;

    assign w_force_i = (r_scnt == SCNT_W'(STARVE_LIMIT));
`else
    assign w_force_i = 1'b0;
`endif

    assign w_grant_i = w_if_pend & (~w_d_pend | w_force_i);
    assign w_grant_d = w_d_pend & ~w_grant_i;

    // Completion on rvalid wins over the terminal count in the same cycle.
    assign w_done    = mem_rvalid | (r_tcnt == TCNT_W'(TIMEOUT - 1));
    assign w_rd_data = (mem_rvalid && !r_mem_we) ? mem_rdata : 32'd0;

    always_comb begin
        w_state_nxt       = r_state;
        w_tcnt_nxt        = r_tcnt;
        w_if_ack_nxt      = 1'b0;
        w_if_rdata_nxt    = r_if_rdata;
        w_d_ack_nxt       = 1'b0;
        w_d_rdata_nxt     = r_d_rdata;
        w_err_nxt         = 1'b0;
        w_mem_en_nxt      = 1'b0;
        w_mem_we_nxt      = r_mem_we;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_wdata_nxt   = r_mem_wdata;
        w_mem_addrctl_nxt = r_mem_addrctl;
`ifdef ARB_STARVE_GUARD_EN
        w_scnt_nxt        = r_scnt;
`endif
        unique case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt       = WAIT_D;
                    w_tcnt_nxt        = '0;
                    w_mem_en_nxt      = 1'b1;
                    w_mem_we_nxt      = d_we;
                    w_mem_addr_nxt    = d_addr;
                    w_mem_wdata_nxt   = d_wdata;
                    w_mem_addrctl_nxt = d_addrctl;
`ifdef ARB_STARVE_GUARD_EN
                    if (if_req) begin
                        w_scnt_nxt = r_scnt + SCNT_W'(1);
                    end
`endif
                end else if (w_grant_i) begin
                    w_state_nxt       = WAIT_I;
                    w_tcnt_nxt        = '0;
                    w_mem_en_nxt      = 1'b1;
                    w_mem_we_nxt      = 1'b0;
                    w_mem_addr_nxt    = if_addr;
                    w_mem_wdata_nxt   = 32'd0;
                    w_mem_addrctl_nxt = 3'd0;
`ifdef ARB_STARVE_GUARD_EN
                    w_scnt_nxt        = '0;
`endif
                end
            end
            WAIT_I, WAIT_D: begin
                if (w_done) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = ~mem_rvalid;
                    if (r_state == WAIT_I) begin
                        w_if_ack_nxt   = 1'b1;
                        w_if_rdata_nxt = w_rd_data;
                    end else begin
                        w_d_ack_nxt    = 1'b1;
                        w_d_rdata_nxt  = w_rd_data;
                    end
                end else begin
                    w_tcnt_nxt = r_tcnt + TCNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_tcnt        <= '0;
            r_if_ack      <= 1'b0;
            r_if_rdata    <= 32'd0;
            r_d_ack       <= 1'b0;
            r_d_rdata     <= 32'd0;
            r_err         <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= 32'd0;
            r_mem_wdata   <= 32'd0;
            r_mem_addrctl <= 3'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_tcnt        <= w_tcnt_nxt;
            r_if_ack      <= w_if_ack_nxt;
            r_if_rdata    <= w_if_rdata_nxt;
            r_d_ack       <= w_d_ack_nxt;
            r_d_rdata     <= w_d_rdata_nxt;
            r_err         <= w_err_nxt;
            r_mem_en      <= w_mem_en_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_mem_addrctl <= w_mem_addrctl_nxt;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scnt <= '0;
        end else begin
            r_scnt <= w_scnt_nxt;
        end
    end
`endif

    assign if_ack      = r_if_ack;
    assign if_rdata    = r_if_rdata;
    assign d_ack       = r_d_ack;
    assign d_rdata     = r_d_rdata;
    assign err         = r_err;
    assign mem_en      = r_mem_en;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_addrctl = r_mem_addrctl;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-timing model.
module tb_mem_port_arbiter;
    localparam int TO = 16;
    localparam int SL = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [2:0]  d_addrctl;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_addrctl;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TO), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addrctl(d_addrctl), .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addrctl(mem_addrctl), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          rv_at    = -100;
    logic [31:0] rv_data  = 32'd0;

    // Transaction model: each access completes at grant + min(latency+1, TO).
    int          m_ack_at;
    bit          m_port_d;
    bit          m_we;
    bit          m_err;
    logic [31:0] m_rdata;
    int          m_scnt;
    int          m_fixed_lat;
    bit          e_en, e_ia, e_da, e_err, e_we;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [2:0]  e_ctl;

    task automatic mem_drive();
        mem_rvalid = (cyc == rv_at);
        mem_rdata  = rv_data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        mem_drive();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0; d_addrctl = 3'd0;
        rv_at = -100; rv_data = 32'd0;
        step();
        step();
        rst = 1'b0;
        m_ack_at = -1000; m_scnt = 0; m_port_d = 1'b0;
    endtask

    task automatic model_step();
        bit ip, dp, gi;
        int lat, r;
        e_en = 1'b0; e_ia = 1'b0; e_da = 1'b0; e_err = 1'b0;
        if (cyc == m_ack_at) begin
            e_ia = !m_port_d; e_da = m_port_d; e_err = m_err; e_rdata = m_rdata;
        end else if (cyc > m_ack_at) begin
            ip = if_req && !((cyc - 1 == m_ack_at) && !m_port_d);
            dp = d_req && !((cyc - 1 == m_ack_at) && m_port_d);
            gi = ip && (!dp || (GUARD && m_scnt == SL));
            if (gi || dp) begin
                e_en = 1'b1;
                m_port_d = !gi;
                if (gi) begin
                    m_scnt = 0; e_we = 1'b0; e_addr = if_addr;
                end else begin
                    if (if_req) m_scnt++;
                    e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_ctl = d_addrctl;
                end
                m_we = e_we;
                if (m_fixed_lat >= 0) lat = m_fixed_lat;
                else begin
                    r = int'($urandom_range(0, 9));
                    if (r < 6) lat = int'($urandom_range(0, 3));
                    else if (r < 8) lat = int'($urandom_range(4, TO - 1));
                    else if (r == 8) lat = TO - 1;
                    else lat = -1;
                end
                rv_data = $urandom;
                if (lat >= 0 && lat + 1 <= TO) begin
                    m_ack_at = cyc + lat + 1; m_err = 1'b0;
                    m_rdata = m_we ? 32'd0 : rv_data;
                    rv_at = cyc + lat;
                end else begin
                    m_ack_at = cyc + TO; m_err = 1'b1; m_rdata = 32'd0;
                    rv_at = -100;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h0000_0040;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0080; d_wdata = 32'hFFFF_FFFF; d_addrctl = 3'b111;
        rv_at = -100; rv_data = 32'hFFFF_FFFF;
        step();
        step();
        n_checks++;
        if ({if_ack, d_ack, err, mem_en, mem_we} !== 5'b0)
            $display("FAIL reset_flags got=%b exp=00000", {if_ack, d_ack, err, mem_en, mem_we});
        else n_pass++;
        n_checks++;
        if ({if_rdata, d_rdata} !== 64'd0)
            $display("FAIL reset_rdata got=%h exp=0", {if_rdata, d_rdata});
        else n_pass++;
        n_checks++;
        if ({mem_addr, mem_wdata, mem_addrctl} !== 67'd0)
            $display("FAIL reset_memcmd got=%h exp=0", {mem_addr, mem_wdata, mem_addrctl});
        else n_pass++;
        apply_reset();
    endtask

    task automatic test_single_load();
        int g;
        apply_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100; d_addrctl = 3'b000;
        step();
        g = cyc;
        n_checks++;
        if ({mem_en, mem_we, mem_addr} !== {2'b10, 32'h0000_0100})
            $display("FAIL load_issue got=%b/%b/%h exp=1/0/00000100", mem_en, mem_we, mem_addr);
        else n_pass++;
        rv_at = g + 3; rv_data = 32'hDEAD_BEEF;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k < 4) begin
                n_checks++;
                if ({mem_en, d_ack, if_ack} !== 3'b000)
                    $display("FAIL load_wait k=%0d got=%b exp=000", k, {mem_en, d_ack, if_ack});
                else n_pass++;
            end
        end
        n_checks++;
        if ({d_ack, err, if_ack, d_rdata} !== {3'b100, 32'hDEAD_BEEF})
            $display("FAIL load_ack got=%b%b%b/%h exp=100/deadbeef", d_ack, err, if_ack, d_rdata);
        else n_pass++;
        d_req = 1'b0;
        step();
        n_checks++;
        if ({d_ack, mem_en} !== 2'b00)
            $display("FAIL load_ack_width got=%b exp=00", {d_ack, mem_en});
        else n_pass++;
    endtask

    task automatic test_store();
        apply_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200;
        d_wdata = 32'h1234_5678; d_addrctl = 3'b010;
        step();
        n_checks++;
        if ({mem_en, mem_we, mem_wdata, mem_addrctl} !== {2'b11, 32'h1234_5678, 3'b010})
            $display("FAIL store_issue got=%b%b/%h/%b exp=11/12345678/010", mem_en, mem_we, mem_wdata, mem_addrctl);
        else n_pass++;
        rv_at = cyc; rv_data = 32'hFFFF_FFFF;
        mem_drive();
        step();
        n_checks++;
        if ({d_ack, err, d_rdata} !== {2'b10, 32'd0})
            $display("FAIL store_ack got=%b%b/%h exp=10/00000000", d_ack, err, d_rdata);
        else n_pass++;
        d_req = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int g;
        apply_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
        step();
        rv_at = -100; rv_data = 32'hCAFE_F00D;
        mem_drive();
        for (int k = 1; k <= TO; k++) begin
            step();
            if (k == 3) d_addr = 32'h0000_0999;
            if (k < TO) begin
                n_checks++;
                if ({d_ack, if_ack, err} !== 3'b000)
                    $display("FAIL timeout_wait k=%0d got=%b exp=000", k, {d_ack, if_ack, err});
                else n_pass++;
            end
        end
        n_checks++;
        if ({d_ack, err, d_rdata, mem_addr} !== {2'b11, 32'd0, 32'h0000_0300})
            $display("FAIL timeout_ack got=%b%b/%h/%h exp=11/00000000/00000300", d_ack, err, d_rdata, mem_addr);
        else n_pass++;
        d_req = 1'b0;
        rv_at = cyc + 2;
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if ({d_ack, if_ack, mem_en, err} !== 4'b0000)
                $display("FAIL late_rvalid k=%0d got=%b exp=0000", k, {d_ack, if_ack, mem_en, err});
            else n_pass++;
        end
        d_req = 1'b1; d_addr = 32'h0000_0304;
        step();
        g = cyc;
        rv_at = g + TO - 1; rv_data = 32'h5A5A_0001;
        for (int k = 1; k <= TO; k++) step();
        n_checks++;
        if ({d_ack, err, d_rdata} !== {2'b10, 32'h5A5A_0001})
            $display("FAIL rvalid_at_terminal got=%b%b/%h exp=10/5a5a0001", d_ack, err, d_rdata);
        else n_pass++;
        d_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        if_req = 1'b1; if_addr = 32'h0000_1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
        step();
        n_checks++;
        if ({mem_en, mem_addr} !== {1'b1, 32'h0000_2000})
            $display("FAIL b2b_first got=%b/%h exp=1/00002000", mem_en, mem_addr);
        else n_pass++;
        rv_at = cyc; rv_data = 32'h0000_D00D;
        mem_drive();
        step();
        n_checks++;
        if ({d_ack, if_ack, mem_en, d_rdata} !== {3'b100, 32'h0000_D00D})
            $display("FAIL b2b_dack got=%b/%h exp=100/0000d00d", {d_ack, if_ack, mem_en}, d_rdata);
        else n_pass++;
        d_req = 1'b0;
        step();
        n_checks++;
        if ({mem_en, mem_we, mem_addr} !== {2'b10, 32'h0000_1000})
            $display("FAIL b2b_second got=%b%b/%h exp=10/00001000", mem_en, mem_we, mem_addr);
        else n_pass++;
        rv_at = cyc; rv_data = 32'h0000_1F1F;
        mem_drive();
        step();
        n_checks++;
        if ({if_ack, d_ack, if_rdata} !== {2'b10, 32'h0000_1F1F})
            $display("FAIL b2b_iack got=%b/%h exp=10/00001f1f", {if_ack, d_ack}, if_rdata);
        else n_pass++;
        if_req = 1'b0;
        step();
    endtask

    task automatic test_starve();
        int n_i, n_i_exp;
        apply_reset();
        m_fixed_lat = 0; n_i = 0; n_i_exp = 0;
        if_req = 1'b1; if_addr = 32'h0000_1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
        for (int t = 0; t < 40; t++) begin
            step();
            model_step();
            mem_drive();
            if (mem_en && mem_addr == 32'h0000_1000) n_i++;
            if (e_en && e_addr == 32'h0000_1000) n_i_exp++;
            n_checks++;
            if ({mem_en, if_ack, d_ack} !== {e_en, e_ia, e_da})
                $display("FAIL starve_seq cyc=%0d got=%b exp=%b", cyc, {mem_en, if_ack, d_ack}, {e_en, e_ia, e_da});
            else n_pass++;
            if (e_en) begin
                n_checks++;
                if (mem_addr !== e_addr)
                    $display("FAIL starve_grant cyc=%0d got=%h exp=%h", cyc, mem_addr, e_addr);
                else n_pass++;
            end
        end
        n_checks++;
        if (n_i != n_i_exp)
            $display("FAIL starve_fetch_grants got=%0d exp=%0d", n_i, n_i_exp);
        else n_pass++;
        if_req = 1'b0; d_req = 1'b0;
        m_fixed_lat = -1;
    endtask

    task automatic test_random();
        apply_reset();
        m_fixed_lat = -1;
        for (int t = 0; t < 1500; t++) begin
            step();
            model_step();
            mem_drive();
            n_checks++;
            if ({mem_en, if_ack, d_ack, err} !== {e_en, e_ia, e_da, e_err})
                $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", cyc, {mem_en, if_ack, d_ack, err}, {e_en, e_ia, e_da, e_err});
            else n_pass++;
            if (e_en) begin
                n_checks++;
                if ({mem_we, mem_addr} !== {e_we, e_addr})
                    $display("FAIL rnd_cmd cyc=%0d got=%b/%h exp=%b/%h", cyc, mem_we, mem_addr, e_we, e_addr);
                else n_pass++;
                if (m_port_d) begin
                    n_checks++;
                    if ({mem_wdata, mem_addrctl} !== {e_wdata, e_ctl})
                        $display("FAIL rnd_wdata cyc=%0d got=%h/%b exp=%h/%b", cyc, mem_wdata, mem_addrctl, e_wdata, e_ctl);
                    else n_pass++;
                end
            end
            if (e_ia) begin
                n_checks++;
                if (if_rdata !== e_rdata)
                    $display("FAIL rnd_if_rdata cyc=%0d got=%h exp=%h", cyc, if_rdata, e_rdata);
                else n_pass++;
            end
            if (e_da) begin
                n_checks++;
                if (d_rdata !== e_rdata)
                    $display("FAIL rnd_d_rdata cyc=%0d got=%h exp=%h", cyc, d_rdata, e_rdata);
                else n_pass++;
            end
            if (!if_req || if_ack) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req || d_ack) begin
                d_req     = ($urandom_range(0, 2) != 0);
                d_we      = $urandom_range(0, 1) == 1;
                d_addr    = $urandom;
                d_wdata   = $urandom;
                d_addrctl = 3'($urandom_range(0, 7));
            end
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400;
        step();
        rv_at = -100;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({if_ack, if_rdata, d_ack, d_rdata, err, mem_en, mem_we, mem_addr, mem_wdata, mem_addrctl} !== 136'd0)
            $display("FAIL reset_mid_outputs got=%b/%h/%b exp=0", {d_ack, mem_en, mem_we}, mem_addr, err);
        else n_pass++;
        step();
        rst = 1'b0;
        n_checks++;
        if (d_ack !== 1'b0)
            $display("FAIL reset_mid_noack got=%b exp=0", d_ack);
        else n_pass++;
        step();
        n_checks++;
        if ({mem_en, d_ack, mem_addr} !== {2'b10, 32'h0000_0400})
            $display("FAIL reset_mid_regrant got=%b/%h exp=10/00000400", {mem_en, d_ack}, mem_addr);
        else n_pass++;
        rv_at = cyc + 1; rv_data = 32'h0BAD_F00D;
        step();
        n_checks++;
        if (d_ack !== 1'b0)
            $display("FAIL reset_mid_early got=%b exp=0", d_ack);
        else n_pass++;
        step();
        n_checks++;
        if ({d_ack, err, d_rdata} !== {2'b10, 32'h0BAD_F00D})
            $display("FAIL reset_mid_served got=%b%b/%h exp=10/0badf00d", d_ack, err, d_rdata);
        else n_pass++;
        d_req = 1'b0;
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        m_fixed_lat = -1;
        m_ack_at    = -1000;
        m_scnt      = 0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'd0;
        test_reset();
        test_single_load();
        test_store();
        test_timeout();
        test_back_to_back();
        test_starve();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
